// File: rtl/apb_slave_regs.sv
// APB slave with NUM_REGS x 32-bit registers; index 0 is a read-only ID.
// Define APB_SLAVE_WAIT_EN to insert WAIT_CYCLES wait states per transfer.
module apb_slave_regs #(
    parameter int NUM_REGS    = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic [31:0] paddr_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    output logic        pready_o,
    output logic [31:0] prdata_o,
    output logic        pslverr_o
);
    localparam int          IDXW   = $clog2(NUM_REGS);
    localparam logic [31:0] ID_VAL = 32'hA9B0_0001;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t          state;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic            write_q;
    logic [31:0]     regs [NUM_REGS];

    logic [IDXW-1:0] idx;
    logic            addr_ok;
    logic            is_id;
    logic            cnt_zero;
    logic            complete;

    assign idx     = addr_q[2 +: IDXW];
    assign is_id   = (idx == '0);
    assign addr_ok = (addr_q[1:0] == 2'b00) && (addr_q[31:2+IDXW] == '0);

`ifdef APB_SLAVE_WAIT_EN
    logic [3:0] cnt;
    assign cnt_zero = (cnt == 4'd0);
`else
    logic [3:0] unused_wait;
    assign unused_wait = 4'(WAIT_CYCLES);
    assign cnt_zero    = 1'b1;
`endif

    // Gated by reset so the bus sees no response while reset is held.
    assign complete  = reset && (state == ACCESS) && psel_i && penable_i && cnt_zero;
    assign pready_o  = complete;
    assign pslverr_o = complete && (!addr_ok || (write_q && is_id));
    assign prdata_o  = (complete && !write_q && addr_ok) ? (is_id ? ID_VAL : regs[idx]) : 32'd0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
`ifdef APB_SLAVE_WAIT_EN
            cnt     <= 4'd0;
`endif
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (psel_i && !penable_i) begin
                        state   <= ACCESS;
                        addr_q  <= paddr_i;
                        write_q <= pwrite_i;
                        wdata_q <= pwdata_i;
`ifdef APB_SLAVE_WAIT_EN
                        cnt     <= 4'(WAIT_CYCLES);
`endif
                    end
                end
                ACCESS: begin
                    if (!psel_i) begin
                        state <= IDLE;
                    end else if (!penable_i) begin
                        // A fresh setup phase mid-transfer restarts the transfer.
                        addr_q  <= paddr_i;
                        write_q <= pwrite_i;
                        wdata_q <= pwdata_i;
`ifdef APB_SLAVE_WAIT_EN
                        cnt     <= 4'(WAIT_CYCLES);
`endif
                    end else if (!cnt_zero) begin
`ifdef APB_SLAVE_WAIT_EN
                        cnt <= cnt - 4'd1;
`endif
                    end else begin
                        state <= IDLE;
                        if (write_q && addr_ok && !is_id) regs[idx] <= wdata_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_slave_regs.sv
// Randomized APB bench for apb_slave_regs against an array-based register model.
module tb_apb_slave_regs;
    localparam int          NUM_REGS    = 8;
    localparam int          WAIT_CYCLES = 2;
    localparam logic [31:0] ID_VAL      = 32'hA9B0_0001;
`ifdef APB_SLAVE_WAIT_EN
    localparam int WAITS = WAIT_CYCLES;
`else
    localparam int WAITS = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic        pready, pslverr;
    logic [31:0] prdata;

    logic [31:0] model [NUM_REGS];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    apb_slave_regs #(.NUM_REGS(NUM_REGS), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk(clk), .reset(reset), .psel_i(psel), .penable_i(penable),
        .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
        .pready_o(pready), .prdata_o(prdata), .pslverr_o(pslverr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        model[0] = ID_VAL;
        for (int i = 1; i < NUM_REGS; i++) model[i] = 32'd0;
    endtask

    // One transfer: setup, access with wait counting, response check.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d);
        logic        valid;
        int          i;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          waits;
        bit          done;
        valid   = (a[1:0] == 2'b00) && (a < 32'(NUM_REGS * 4));
        i       = int'(a >> 2);
        exp_rd  = (valid && !w) ? model[i] : 32'd0;
        exp_err = !valid || (w && i == 0);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
        @(negedge clk);
        chk("setup_ready", 32'(pready), 32'd0);
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        done  = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (pready) done = 1;
            else begin
                chk("wait_rdata", prdata, 32'd0);
                waits++;
                @(posedge clk); #1;
            end
        end
        if (!done) chk("timeout", 32'd0, 32'd1);
        else begin
            chk("waits", 32'(waits), 32'(WAITS));
            chk("rdata", prdata, exp_rd);
            chk("slverr", 32'(pslverr), 32'(exp_err));
        end
        if (w && valid && i != 0) model[i] = d;
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        model_reset();
        // Reset with bus pins active: no response allowed.
        psel = 1'b1; penable = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(pready), 32'd0);
        chk("rst_rdata", prdata, 32'd0);
        chk("rst_slverr", 32'(pslverr), 32'd0);
        #1; psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1; reset = 1'b1;

        for (int k = 0; k < NUM_REGS; k++) xfer(32'(k * 4), 1'b0, 32'd0);

        // Abort a write to 0x04 after the first wait cycle (or right after setup).
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 32'h04; pwrite = 1'b1; pwdata = 32'h1234;
        if (WAITS > 0) begin @(posedge clk); #1; penable = 1'b1; end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(pready), 32'd0);
        xfer(32'h04, 1'b0, 32'd0);

        xfer(32'h08, 1'b1, 32'hDEAD_BEEF);
        xfer(32'h08, 1'b0, 32'd0);
        xfer(32'h00, 1'b1, 32'h5555_AAAA);
        xfer(32'h00, 1'b0, 32'd0);
        xfer(32'h20, 1'b0, 32'd0);
        xfer(32'h06, 1'b0, 32'd0);
        xfer(32'h8000_0004, 1'b1, 32'hFFFF_FFFF);
        xfer(32'h04, 1'b0, 32'd0);

        // Restart: a second setup replaces the first before any access.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 32'h0C; pwrite = 1'b1; pwdata = 32'hAAAA_0000;
        xfer(32'h10, 1'b1, 32'hBBBB_0000);
        xfer(32'h0C, 1'b0, 32'd0);
        xfer(32'h10, 1'b0, 32'd0);

        for (int n = 0; n < 200; n++)
            xfer(32'($urandom_range(1, NUM_REGS - 1) * 4), 1'($urandom_range(0, 1)), $urandom);

        // Reset during the access phase of a write.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 32'h08; pwrite = 1'b1; pwdata = 32'h7777_7777;
        @(posedge clk); #1;
        penable = 1'b1; reset = 1'b0;
        @(negedge clk);
        chk("midrst_ready0", 32'(pready), 32'd0);
        @(negedge clk);
        chk("midrst_ready1", 32'(pready), 32'd0);
        chk("midrst_slverr", 32'(pslverr), 32'd0);
        #1; reset = 1'b1; psel = 1'b0; penable = 1'b0;
        model_reset();
        for (int k = 0; k < NUM_REGS; k++) xfer(32'(k * 4), 1'b0, 32'd0);
        go_idle();
        @(negedge clk);
        chk("idle_ready", 32'(pready), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/apb_slave_regs.md
APB_SLAVE_REGS -- requirements
Module: apb_slave_regs

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 8, giving the number of 32-bit registers (power of two, 2..256).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, giving the wait states inserted per transfer when APB_SLAVE_WAIT_EN is defined (0..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic samples on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: a synchronous, active-low reset (0 = reset).
REQ-005 The block SHALL have port psel_i, input, 1 bit: APB select.
REQ-006 The block SHALL have port penable_i, input, 1 bit: APB enable, which marks the access phase.
REQ-007 The block SHALL have port paddr_i, input, 32 bits: byte address.
REQ-008 The block SHALL have port pwrite_i, input, 1 bit: 1 = write, 0 = read.
REQ-009 The block SHALL have port pwdata_i, input, 32 bits: write data.
REQ-010 The block SHALL have port pready_o, output, 1 bit: transfer completes in a cycle where psel_i, penable_i and pready_o are all 1.
REQ-011 The block SHALL have port prdata_o, output, 32 bits: read data, valid in the completion cycle of a read.
REQ-012 The block SHALL have port pslverr_o, output, 1 bit: error response, valid only in the completion cycle.

Function
REQ-013 The FSM SHALL have states IDLE and ACCESS.
REQ-014 IDLE -> ACCESS SHALL occur when psel_i=1 and penable_i=0 at a clock edge (setup phase).
- Captured on that edge: paddr_i, pwrite_i, pwdata_i.
- Wait counter loaded with WAIT_CYCLES.
REQ-015 In ACCESS with psel_i=1 and penable_i=1:
- counter != 0: decrement the counter; pready_o=0.
- counter == 0: pready_o=1 (combinational from state and counter).
REQ-016 The completion cycle SHALL return the FSM to IDLE; back-to-back transfers therefore take one setup cycle plus one access cycle each, with no dead cycle.
REQ-017 Register index SHALL be the captured paddr[2 +: log2(NUM_REGS)].
REQ-018 An address SHALL be valid only if paddr[1:0]==0 and all captured bits above the index field are 0.
REQ-019 A write to a valid address other than index 0 SHALL update the register on the completion edge.
REQ-020 Index 0 SHALL be a read-only ID register with value 32'hA9B0_0001; a write to it SHALL be ignored and give pslverr_o=1.
REQ-021 An invalid address SHALL give pslverr_o=1 and prdata_o=0 in the completion cycle, and SHALL NOT modify any register.
REQ-022 Outside the completion cycle: prdata_o=0, pslverr_o=0, pready_o=0.
REQ-023 In the completion cycle of a write: prdata_o=0.
REQ-024 If psel_i drops in ACCESS before completion (protocol abort), the FSM SHALL go to IDLE with no register write.
REQ-025 In ACCESS with psel_i=1 and penable_i=0, the transfer SHALL restart as a new setup: recapture the address and controls, and reload the counter.

Reset
REQ-026 While reset=0 at a clock edge, the block SHALL enter IDLE, clear the wait counter, and clear registers 1..NUM_REGS-1 to 0.
REQ-027 During reset: pready_o=0, prdata_o=0, pslverr_o=0.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer with no write; the first setup after release is accepted normally.

Configuration
REQ-029 Macro APB_SLAVE_WAIT_EN defined: each transfer SHALL insert WAIT_CYCLES wait states (pready_o low for WAIT_CYCLES access cycles).
REQ-030 Macro APB_SLAVE_WAIT_EN undefined: the wait counter SHALL be absent, and pready_o=1 in the first access cycle (zero-wait).

Verification
REQ-031 Zero-wait path (macro undefined): write 32'hDEAD_BEEF to 0x08, then read 0x08 -> each transfer takes 2 cycles; prdata_o=32'hDEAD_BEEF; pslverr_o=0.
REQ-032 Wait-state path (macro defined, WAIT_CYCLES=2): read 0x00 -> pready_o low for exactly 2 access cycles, then high; prdata_o=32'hA9B0_0001.
REQ-033 Error cases:
- Write 0x00 -> pslverr_o=1; a following read of 0x00 returns 32'hA9B0_0001.
- Read 0x20 with NUM_REGS=8 -> pslverr_o=1, prdata_o=0.
- Read 0x06 -> pslverr_o=1, prdata_o=0.
REQ-034 Abort: drop psel_i after the first wait cycle of a write of 32'h1234 to 0x04 -> a read of 0x04 returns the old value 0.
REQ-035 Reset mid-transfer and initial state:
- Assert reset=0 in ACCESS -> next cycle pready_o=0, and all registers 1..7 read back 0.
- Random back-to-back mixed transfers to 0x04..0x1C checked against a reference model.
